// File: rtl/sd_writer.sv
// SD 4-bit data-bus block writer: streams one block out on DAT[3:0] with per-line
// CRC16, then collects the card's CRC status token and waits for busy release.
module sd_writer #(
  parameter logic [15:0] TIMEOUT = 16'd50000,
  parameter int          NWR     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start_writing,
  input  logic [9:0] i_buf_len,
  input  logic [7:0] i_st_data,
  input  logic       i_st_vld,
  output logic       o_st_rdy,
  output logic [3:0] o_sd_data,
  output logic       o_sd_oe,
  input  logic [3:0] i_sd_data,
  output logic       o_sd_run,
  output logic       o_done,
  output logic [2:0] o_status,
  output logic       o_error,
  output logic [3:0] o_dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_START, S_TX, S_CRC, S_END, S_TURN, S_STATUS, S_BUSY
  } state_t;

  state_t           state_q, state_d;
  logic             start_d1_q, start_d1_d;
  logic [10:0]      len_q, len_d;
  logic [10:0]      acc_q, acc_d;
  logic [10:0]      sent_q, sent_d;
  logic [7:0]       hold_q, hold_d;
  logic             full_q, full_d;
  logic [7:0]       shift_q, shift_d;
  logic             nib_q, nib_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [3:0][15:0] crc_q, crc_d;
  logic [2:0]       status_q, status_d;
  logic             error_q, error_d;
  logic             done_q, done_d;

  logic             start_edge;
  logic             xfer;
  logic             dat0;
  logic [3:0]       tx_nib;
  logic [15:0]      tmo_inc;
  logic             unused_pads;

  assign unused_pads = ^i_sd_data[3:1];
  assign dat0        = i_sd_data[0];
  assign start_edge  = i_start_writing & ~start_d1_q;
  assign tx_nib      = nib_q ? shift_q[3:0] : shift_q[7:4];
  assign tmo_inc     = (tmo_q != 16'hFFFF) ? tmo_q + 16'd1 : tmo_q;

  // Upstream handshake: a byte moves into the holding register on any clock edge
  // where i_st_vld and o_st_rdy are both high; i_st_data must be stable while
  // i_st_vld is high and o_st_rdy is low. o_st_rdy never depends on i_st_vld.
  assign o_st_rdy = ((state_q == S_PRE) || (state_q == S_TX)) && !full_q && (acc_q < len_q);
  assign xfer     = i_st_vld & o_st_rdy;

  assign o_sd_run    = (state_q != S_IDLE);
  assign o_done      = done_q;
  assign o_status    = status_q;
  assign o_error     = error_q;
  assign o_dbg_state = state_q;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  always_comb begin
    state_d    = state_q;
    start_d1_d = i_start_writing;
    len_d      = len_q;
    acc_d      = acc_q;
    sent_d     = sent_q;
    hold_d     = hold_q;
    full_d     = full_q;
    shift_d    = shift_q;
    nib_d      = nib_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    crc_d      = crc_q;
    status_d   = status_q;
    error_d    = error_q;
    done_d     = 1'b0;
    o_sd_data  = 4'hF;
    o_sd_oe    = 1'b0;

    if (xfer) begin
      hold_d = i_st_data;
      full_d = 1'b1;
      acc_d  = acc_q + 11'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          len_d    = (i_buf_len == 10'd0) ? 11'd512 : {1'b0, i_buf_len};
          acc_d    = '0;
          sent_d   = '0;
          full_d   = 1'b0;
          nib_d    = 1'b0;
          cnt_d    = '0;
          crc_d    = '0;
          error_d  = 1'b0;
          status_d = '0;
          state_d  = S_PRE;
        end
      end
      S_PRE: begin
        o_sd_oe = 1'b1;
        if (cnt_q < 8'(NWR - 1)) begin
          cnt_d = cnt_q + 8'd1;
        end else if (full_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        o_sd_oe   = 1'b1;
        o_sd_data = 4'h0;
        shift_d   = hold_q;
        full_d    = 1'b0;
        sent_d    = 11'd1;
        nib_d     = 1'b0;
        state_d   = S_TX;
      end
      S_TX: begin
        o_sd_oe   = 1'b1;
        o_sd_data = tx_nib;
        for (int n = 0; n < 4; n++) crc_d[n] = crc_step(crc_q[n], tx_nib[n]);
        nib_d = ~nib_q;
        if (nib_q) begin
          if (sent_q == len_q) begin
            cnt_d   = '0;
            state_d = S_CRC;
          end else if (full_q) begin
            shift_d = hold_q;
            full_d  = 1'b0;
            sent_d  = sent_q + 11'd1;
          end else begin
            // Underrun: abandon the block rather than stall a clocked card.
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_CRC: begin
        o_sd_oe   = 1'b1;
        o_sd_data = {crc_q[3][15], crc_q[2][15], crc_q[1][15], crc_q[0][15]};
        for (int n = 0; n < 4; n++) crc_d[n] = {crc_q[n][14:0], 1'b0};
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd15) state_d = S_END;
      end
      S_END: begin
        o_sd_oe   = 1'b1;
        o_sd_data = 4'hF;
        cnt_d     = '0;
        state_d   = S_TURN;
      end
      S_TURN: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd1) begin
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = S_STATUS;
        end
      end
      S_STATUS: begin
        if (cnt_q == 8'd0) begin
          if (!dat0) begin
            cnt_d = 8'd1;
          end else if (tmo_q >= TIMEOUT - 16'd1) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            tmo_d = tmo_inc;
          end
        end else if (cnt_q < 8'd4) begin
          status_d = {status_q[1:0], dat0};
          cnt_d    = cnt_q + 8'd1;
        end else begin
          if (!dat0 || (status_q != 3'b010)) error_d = 1'b1;
          tmo_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (dat0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (tmo_q >= TIMEOUT - 16'd1) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      start_d1_q <= 1'b0;
      len_q      <= '0;
      acc_q      <= '0;
      sent_q     <= '0;
      hold_q     <= '0;
      full_q     <= 1'b0;
      shift_q    <= '0;
      nib_q      <= 1'b0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      crc_q      <= '0;
      status_q   <= '0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_d1_q <= start_d1_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      sent_q     <= sent_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      shift_q    <= shift_d;
      nib_q      <= nib_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      crc_q      <= crc_d;
      status_q   <= status_d;
      error_q    <= error_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_sd_writer.sv
// Bench for sd_writer: random blocks, a behavioural card model on DAT0, and a
// scoreboard comparing every driven DAT nibble and every block completion.
module tb_sd_writer;

  localparam logic [15:0] TMO = 16'd300;
  localparam int          NWR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start_writing = 1'b0;
  logic [9:0] i_buf_len = '0;
  logic [7:0] i_st_data = '0;
  logic       i_st_vld = 1'b0;
  logic       o_st_rdy;
  logic [3:0] o_sd_data;
  logic       o_sd_oe;
  logic [3:0] sd_in = 4'hF;
  logic       o_sd_run;
  logic       o_done;
  logic [2:0] o_status;
  logic       o_error;
  logic [3:0] dbg_state;

  always #5 clk = ~clk;

  sd_writer #(.TIMEOUT(TMO), .NWR(NWR)) dut (
    .clk(clk), .rst_n(rst_n), .i_start_writing(i_start_writing),
    .i_buf_len(i_buf_len), .i_st_data(i_st_data), .i_st_vld(i_st_vld),
    .o_st_rdy(o_st_rdy), .o_sd_data(o_sd_data), .o_sd_oe(o_sd_oe),
    .i_sd_data(sd_in), .o_sd_run(o_sd_run), .o_done(o_done),
    .o_status(o_status), .o_error(o_error), .o_dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // exp_q: one DAT nibble per expected oe-high cycle.
  // res_q: {gap_lo[47:32], gap_hi[31:16], oe_cycles[15:4], error[3], status[2:0]}
  logic [3:0]  exp_q[$];
  logic [47:0] res_q[$];
  int oe_cnt = 0;
  int cyc = 0;
  int last_oe_cyc = 0;
  int done_cnt = 0;

  logic [7:0] blk [1024];

  int         card_mode = 0;   // 0 normal, 1 silent, 2 busy forever
  logic [2:0] card_tok = 3'b010;
  logic       card_end = 1'b1;
  int         card_busy = 0;
  int         card_dly = 2;
  logic       card_prev_oe = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string why);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, why);
  endtask

  // CRC16-CCITT (x^16+x^12+x^5+1, init 0) over the bit stream of one DAT line.
  function automatic logic [15:0] line_crc(input int len, input int n);
    logic [15:0] c;
    logic        b;
    c = 16'h0000;
    for (int i = 0; i < len; i++) begin
      for (int h = 1; h >= 0; h--) begin
        b = blk[i][4*h + n];
        c = (c[15] ^ b) ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
    end
    return c;
  endfunction

  // Scoreboard monitor
  initial begin
    logic [47:0] r;
    int gap;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (o_sd_oe) begin
          oe_cnt++;
          last_oe_cyc = cyc;
          if (exp_q.size() == 0) fail("dat_extra", $sformatf("unexpected nibble 0x%0h", o_sd_data));
          else check("dat", o_sd_data, exp_q.pop_front());
        end
        if (o_done) begin
          done_cnt++;
          if (res_q.size() == 0) begin
            fail("done_extra", "o_done with no block outstanding");
          end else begin
            r = res_q.pop_front();
            check("done_error", o_error, r[3]);
            check("done_status", o_status, r[2:0]);
            check("oe_cycles", oe_cnt, r[15:4]);
            check("done_idle", {o_sd_run, o_sd_oe}, 2'b00);
            check("dat_left", exp_q.size(), 0);
            if (r[31:16] != 0) begin
              gap = cyc - last_oe_cyc;
              n_tests++;
              if (gap < int'(r[47:32]) || gap > int'(r[31:16])) begin
                n_fail++;
                $display("FAIL done_gap: got %0d cycles expected %0d..%0d", gap, r[47:32], r[31:16]);
              end
            end
          end
          oe_cnt = 0;
        end
      end
    end
  end

  // Card model: answers on DAT0 after the writer releases the bus.
  initial begin
    forever begin
      @(negedge clk);
      if (card_prev_oe && !o_sd_oe && o_sd_run && card_mode != 1) begin
        sd_in = 4'hF;
        repeat (card_dly) @(negedge clk);
        sd_in[0] = 1'b0;
        for (int i = 2; i >= 0; i--) begin
          @(negedge clk);
          sd_in[0] = card_tok[i];
        end
        @(negedge clk);
        sd_in[0] = card_end;
        if (card_mode == 2) begin
          @(negedge clk);
          sd_in[0] = 1'b0;
        end else begin
          repeat (card_busy) begin
            @(negedge clk);
            sd_in[0] = 1'b0;
          end
          @(negedge clk);
          sd_in[0] = 1'b1;
        end
      end
      card_prev_oe = o_sd_oe;
    end
  end

  // pat: 0 zeros, 1 i%256, 2 random, 3 0xA5. under_k: bytes supplied before
  // the stream stalls (0 = all). rst_at: assert reset once that many bytes went in.
  task automatic run_block(input int len_cfg, input int pat, input int mode,
                           input logic [2:0] tok, input logic endb, input int busy,
                           input int under_k, input int rst_at);
    int len, nfeed, idx, guard, d0;
    logic xfer, err;
    logic [15:0] crc [4];
    logic [2:0] st;
    logic [15:0] glo, ghi;
    len = (len_cfg == 0) ? 512 : len_cfg;
    for (int i = 0; i < len; i++) begin
      case (pat)
        0: blk[i] = 8'h00;
        1: blk[i] = 8'(i % 256);
        2: blk[i] = 8'($urandom_range(0, 255));
        default: blk[i] = 8'hA5;
      endcase
    end
    nfeed = (under_k != 0) ? under_k : len;

    repeat (NWR) exp_q.push_back(4'hF);
    exp_q.push_back(4'h0);
    for (int i = 0; i < nfeed; i++) begin
      exp_q.push_back(blk[i][7:4]);
      exp_q.push_back(blk[i][3:0]);
    end
    if (under_k == 0) begin
      for (int n = 0; n < 4; n++) crc[n] = line_crc(len, n);
      for (int b = 15; b >= 0; b--) exp_q.push_back({crc[3][b], crc[2][b], crc[1][b], crc[0][b]});
      exp_q.push_back(4'hF);
      st  = (mode == 1) ? 3'b000 : tok;
      err = (mode != 0) || (tok != 3'b010) || !endb;
      glo = (mode == 1) ? TMO : 16'd0;
      ghi = (mode == 1) ? TMO + 16'd4 : 16'd0;
      if (rst_at == 0) res_q.push_back({glo, ghi, 12'(NWR + 1 + 2*len + 17), err, st});
    end else begin
      if (rst_at == 0) res_q.push_back({16'd1, 16'd1, 12'(NWR + 1 + 2*nfeed), 1'b1, 3'b000});
    end

    card_mode = mode;
    card_tok  = tok;
    card_end  = endb;
    card_busy = busy;
    card_dly  = $urandom_range(2, 8);
    sd_in     = 4'hF;
    d0        = done_cnt;

    @(negedge clk);
    i_buf_len       = len_cfg[9:0];
    i_start_writing = 1'b1;
    i_st_vld        = 1'b1;
    i_st_data       = blk[0];
    idx   = 0;
    guard = 0;
    while (idx < nfeed && guard < 20000) begin
      @(negedge clk);
      i_start_writing = 1'b0;
      xfer = o_st_rdy;
      @(posedge clk);
      #1;
      guard++;
      if (xfer) begin
        idx++;
        if (idx < nfeed) i_st_data = blk[idx];
        else i_st_vld = 1'b0;
      end
      if (rst_at != 0 && idx == rst_at) break;
    end
    i_st_vld        = 1'b0;
    i_start_writing = 1'b0;
    if (guard >= 20000) fail("feed_timeout", $sformatf("only %0d of %0d bytes taken", idx, nfeed));

    if (rst_at != 0) begin
      rst_n = 1'b0;
      #1;
      check("rst_oe", o_sd_oe, 1'b0);
      check("rst_data", o_sd_data, 4'hF);
      check("rst_run", o_sd_run, 1'b0);
      check("rst_rdy", o_st_rdy, 1'b0);
      check("rst_done", o_done, 1'b0);
      exp_q.delete();
      oe_cnt = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      return;
    end

    guard = 0;
    while (done_cnt == d0 && guard < 2*int'(TMO) + 5000) begin
      @(posedge clk);
      guard++;
    end
    if (done_cnt == d0) begin
      fail("done_timeout", $sformatf("no o_done for len %0d", len));
      exp_q.delete();
      res_q.delete();
      oe_cnt = 0;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_data", o_sd_data, 4'hF);
    check("reset_oe", o_sd_oe, 1'b0);
    check("reset_rdy", o_st_rdy, 1'b0);
    check("reset_run", o_sd_run, 1'b0);
    check("reset_done", o_done, 1'b0);
    check("reset_status", o_status, 3'b000);
    check("reset_error", o_error, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_block(0, 0, 0, 3'b010, 1'b1, 10, 0, 0);                       // zero block
    run_block(0, 1, 0, 3'b010, 1'b1, $urandom_range(0, 20), 0, 0);    // i%256 block
    run_block(1, 3, 0, 3'b010, 1'b1, 3, 0, 0);                        // nibble order
    run_block(4, 2, 0, 3'b010, 1'b1, 0, 2, 0);                        // underrun
    run_block(6, 2, 0, 3'b101, 1'b1, 5, 0, 0);                        // bad token
    run_block(3, 2, 1, 3'b010, 1'b1, 0, 0, 0);                        // no status
    run_block(2, 2, 2, 3'b010, 1'b1, 0, 0, 0);                        // busy stuck
    run_block(5, 2, 0, 3'b010, 1'b0, 2, 0, 0);                        // bad end bit
    run_block(8, 2, 0, 3'b010, 1'b1, 0, 0, 2);                        // reset mid-TX
    for (int t = 0; t < 4; t++)
      run_block($urandom_range(1, 40), 2, 0, 3'b010, 1'b1, $urandom_range(0, 20), 0, 0);
    run_block(1023, 2, 0, 3'b010, 1'b1, 1, 0, 0);                     // longest block

    check("res_left", res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_writer.md
Name: sd_writer

Overview:
- Transmit side of the 4-bit SD data bus; the write-path counterpart of the SD data block reader.
- Takes one block of bytes from an upstream stream (valid/ready) and drives DAT[3:0] in this order: start bit, data nibbles, per-line CRC16, end bit.
- Then releases the bus, captures the card's CRC status token on DAT0 and waits out the card busy period.
- Sits between the block buffer and the SD pad tristate, clocked by the SD card clock.

Parameters:
- TIMEOUT, 16'd50000: maximum cycles spent waiting for the status start bit, and separately for busy release, before abort.
- NWR, 2: cycles DAT[3:0] is driven high before the start bit. Minimum 2.

Ports:
- clk  in  1  SD clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- i_start_writing  in  1  a 0->1 edge (registered copy vs. current) starts one block.
- i_buf_len  in  10  bytes per block, sampled at start. 0 means 512.
- i_st_data  in  8  upstream byte.
- i_st_vld  in  1  upstream byte valid.
- o_st_rdy  out  1  writer can accept a byte this cycle.
- o_sd_data  out  4  DAT[3:0] drive value.
- o_sd_oe  out  1  DAT output enable (1 = writer drives the bus).
- i_sd_data  in  4  DAT[3:0] sampled from the pads; only bit 0 is used.
- o_sd_run  out  1  high whenever state != IDLE.
- o_done  out  1  one-cycle pulse at block completion, success or error.
- o_status  out  3  last CRC status token bits; 3'b010 = accepted.
- o_error  out  1  sticky; cleared at the next start.

Behaviour:
- Reset values: o_sd_data=4'hF, o_sd_oe=0, o_st_rdy=0, o_sd_run=0, o_done=0, o_status=0, o_error=0, state=IDLE, all CRCs 0.
- Reset mid-operation returns to IDLE immediately and releases the bus (o_sd_oe=0).
- Holding register: one byte plus a full flag.
  - o_st_rdy = ~full while in PRE or TX and bytes_accepted < len.
  - A transfer happens when o_st_vld & o_st_rdy.
- IDLE:
  - On start edge: latch len, clear CRCs, counters, o_error and o_status; go to PRE.
  - Edges seen while busy (not in IDLE) are ignored.
- PRE:
  - oe=1, data=4'hF.
  - Stay at least NWR cycles and until holding is full (no timeout; the bus is simply held high).
  - Then go to START.
- START: one cycle with data=4'h0, oe=1. The holding byte moves to the shift register.
- TX: two cycles per byte.
  - Cycle A drives byte[7:4], cycle B drives byte[3:0]; DAT3 carries the MSB of each nibble.
  - At the end of cycle B, the next byte moves from holding to the shift register.
  - If more bytes are due and holding is empty at that point: underrun. Set o_error, oe=0, pulse o_done, go to IDLE.
  - After the last cycle B, go to CRC.
- CRC per line n (0..3):
  - Serial CRC16-CCITT, polynomial x^16+x^12+x^5+1, init 0.
  - Updated on every TX cycle with the bit driven on DATn: fb = crc[15]^bit; crc = {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 16'h0).
  - Start and end bits are not included.
- CRC state: 16 cycles; each line drives its own crc[15] first, shifting left.
- END: one cycle with data=4'hF.
- TURN: 2 cycles with oe=0.
- STATUS:
  - Wait for i_sd_data[0]==0 (start bit), then shift 3 bits MSB first into o_status, then one end-bit cycle.
  - If the end bit is not 1, or status != 3'b010: set o_error (still proceed to BUSY).
  - No start bit within TIMEOUT cycles: o_error, o_done pulse, IDLE.
- BUSY:
  - Wait for i_sd_data[0]==1, then pulse o_done and go to IDLE.
  - TIMEOUT expiry: o_error, o_done pulse, IDLE.
- Timing for len bytes with NWR=2 and no stalls:
  - oe high for 2 + 1 + 2*len + 16 + 1 cycles.
  - len=512 gives 1044 cycles.
- Counters:
  - Byte counter is 11 bits so that len=512/1023 never wraps.
  - The timeout counter saturates and does not wrap.

Test Plan:
- Zero block: len=512, bytes 0x00, card returns status 010 with busy 10 cycles.
  - Required: DAT shows 2 cycles of F, one 0, 1024 cycles of 0.
  - Each line CRC = 0x0000 (16 cycles of 0), then F.
  - o_status=010, o_done after busy, o_error=0.
- Loopback: len=512, bytes i%256.
  - Required: the team's SD data block reader, driven from o_sd_data, receives identical bytes with its 4-bit CRC error result = 0.
- Nibble order: len=1, byte 0xA5.
  - Required: after the start bit, DAT = A then 5, followed by 16 CRC cycles. Total oe-high cycles = 22.
- Underrun: len=4, i_st_vld dropped after 2 bytes.
  - Required: o_error=1 at the end of the byte-2 low nibble, oe=0 next cycle, o_done pulse, o_sd_run=0.
- Bad token: card returns status 101.
  - Required: o_status=101, o_error=1, busy still honoured, o_done pulse.
- Timeout and reset:
  - DAT0 held high after TURN: o_error after TIMEOUT cycles.
  - rst_n asserted mid-TX: oe=0 and o_sd_data=F immediately.
